// File: rtl/fsm1_route_core.sv
// Pulse-driven 4-state Mealy FSM with edge-captured event inputs.
// Define FSM1_STATE_OBS_EN to drive the state onto state_obs1_Pad/state_obs0_Pad; otherwise both pins are tied low.
//
// state | meaning
// ------+---------------------------------------------------
// S0    | idle, no event seen yet
// S1    | input1 seen, waiting for input2
// S2    | input2 seen, waiting for input1
// S3    | both seen; next input1/input2 completes (output1)
module fsm1_route_core #(
   parameter logic [1:0] RESET_STATE = 2'b00
) (
   input  logic GCLK_Pad,
   input  logic rst_n_Pad,
   input  logic input1_Pad,
   input  logic input2_Pad,
   input  logic reset_Pad,
   output logic state_obs0_Pad,
   output logic state_obs1_Pad,
   output logic output1_Pad
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t state;
   logic   tog_a, tog_b, tog_r;
   logic   ack_a, ack_b, ack_r;
   logic   pend_a, pend_b, pend_r;

   // Each pulse flips its toggle; the GCLK side sees an event while toggle != ack.
   always_ff @(posedge input1_Pad or negedge rst_n_Pad) begin
      if (!rst_n_Pad) tog_a <= 1'b0;
      else            tog_a <= ~tog_a;
   end

   always_ff @(posedge input2_Pad or negedge rst_n_Pad) begin
      if (!rst_n_Pad) tog_b <= 1'b0;
      else            tog_b <= ~tog_b;
   end

   always_ff @(posedge reset_Pad or negedge rst_n_Pad) begin
      if (!rst_n_Pad) tog_r <= 1'b0;
      else            tog_r <= ~tog_r;
   end

   assign pend_a = tog_a ^ ack_a;
   assign pend_b = tog_b ^ ack_b;
   assign pend_r = tog_r ^ ack_r;

   // Acks copy the same toggle value the pending flag was formed from, so a
   // pulse landing on the edge is either consumed now or stays pending.
   always_ff @(posedge GCLK_Pad or negedge rst_n_Pad) begin
      if (!rst_n_Pad) begin
         state       <= state_t'(RESET_STATE);
         output1_Pad <= 1'b0;
         ack_a       <= 1'b0;
         ack_b       <= 1'b0;
         ack_r       <= 1'b0;
      end else begin
         ack_a       <= tog_a;
         ack_b       <= tog_b;
         ack_r       <= tog_r;
         output1_Pad <= 1'b0;
         if (pend_r) begin
            state <= state_t'(RESET_STATE);
         end else begin
            case (state)
               S0: begin
                  if (pend_a && pend_b) state <= S3;
                  else if (pend_a)      state <= S1;
                  else if (pend_b)      state <= S2;
               end
               S1: if (pend_b) state <= S3;
               S2: if (pend_a) state <= S3;
               S3: begin
                  if (pend_a || pend_b) begin
                     state       <= S0;
                     output1_Pad <= 1'b1;
                  end
               end
               default: state <= state_t'(RESET_STATE);
            endcase
         end
      end
   end

`ifdef FSM1_STATE_OBS_EN
   assign state_obs0_Pad = state[0];
   assign state_obs1_Pad = state[1];
`else
   assign state_obs0_Pad = 1'b0;
   assign state_obs1_Pad = 1'b0;
`endif

endmodule

// File: tb/tb_fsm1_route_core.sv
// Directed bench for fsm1_route_core; expected state/output values are hand-derived per step.
module tb_fsm1_route_core;

`ifdef FSM1_STATE_OBS_EN
   localparam bit OBS_EN = 1'b1;
`else
   localparam bit OBS_EN = 1'b0;
`endif

   logic GCLK_Pad = 1'b0;
   logic rst_n_Pad = 1'b0;
   logic input1_Pad = 1'b0;
   logic input2_Pad = 1'b0;
   logic reset_Pad = 1'b0;
   logic state_obs0_Pad, state_obs1_Pad, output1_Pad;

   int n_cmp = 0;
   int n_bad = 0;

   fsm1_route_core #(.RESET_STATE(2'b00)) dut (
      .GCLK_Pad      (GCLK_Pad),
      .rst_n_Pad     (rst_n_Pad),
      .input1_Pad    (input1_Pad),
      .input2_Pad    (input2_Pad),
      .reset_Pad     (reset_Pad),
      .state_obs0_Pad(state_obs0_Pad),
      .state_obs1_Pad(state_obs1_Pad),
      .output1_Pad   (output1_Pad)
   );

   always #5 GCLK_Pad = ~GCLK_Pad;

   task automatic chk(input string tag, input logic [1:0] obs_exp, input logic out_exp);
      logic [1:0] eo;
      logic [1:0] ob;
      eo = OBS_EN ? obs_exp : 2'b00;
      ob = {state_obs1_Pad, state_obs0_Pad};
      n_cmp++;
      assert (ob === eo) else begin
         n_bad++;
         $error("FAIL %s state_obs: observed %b expected %b", tag, ob, eo);
      end
      n_cmp++;
      assert (output1_Pad === out_exp) else begin
         n_bad++;
         $error("FAIL %s output1: observed %b expected %b", tag, output1_Pad, out_exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge GCLK_Pad);
      #1;
   endtask

   // Short pulse (2 ns), issued 1 ns after an edge so it lands mid-period.
   task automatic pulse(input logic a, input logic b, input logic r);
      input1_Pad = a;
      input2_Pad = b;
      reset_Pad  = r;
      #2;
      input1_Pad = 1'b0;
      input2_Pad = 1'b0;
      reset_Pad  = 1'b0;
   endtask

   initial begin
      // Reset and idle
      #3;
      chk("async_rst", 2'b00, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      tick();
      chk("rst_held_pulse_dropped", 2'b00, 1'b0);
      @(negedge GCLK_Pad);
      rst_n_Pad = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("idle_%0d", i), 2'b00, 1'b0);
      end
      pulse(1'b0, 1'b0, 1'b1); tick(); chk("rpulse_s0", 2'b00, 1'b0);

      // Both inputs then completion
      pulse(1'b1, 1'b1, 1'b0); tick(); chk("s0_ab", 2'b11, 1'b0);
      pulse(1'b1, 1'b0, 1'b0); tick(); chk("s3_a_done", 2'b00, 1'b1);
      tick(); chk("done_one_cycle", 2'b00, 1'b0);

      // Input2 hold, then functional reset
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("s0_b", 2'b10, 1'b0);
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("s2_b_hold", 2'b10, 1'b0);
      tick(); chk("s2_idle", 2'b10, 1'b0);
      pulse(1'b0, 1'b0, 1'b1); tick(); chk("s2_rpulse", 2'b00, 1'b0);

      // Full sequence
      pulse(1'b0, 1'b0, 1'b1); tick(); chk("seq_r", 2'b00, 1'b0);
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("seq_b", 2'b10, 1'b0);
      pulse(1'b1, 1'b1, 1'b0); tick(); chk("seq_s2_ab", 2'b11, 1'b0);
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("seq_s3_b_done", 2'b00, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("seq_idle_%0d", i), 2'b00, 1'b0);
      end

      // S1 path: a holds, b advances
      pulse(1'b1, 1'b0, 1'b0); tick(); chk("s0_a", 2'b01, 1'b0);
      pulse(1'b1, 1'b0, 1'b0); tick(); chk("s1_a_hold", 2'b01, 1'b0);
      tick(); chk("s1_idle", 2'b01, 1'b0);
      pulse(1'b1, 1'b1, 1'b0); tick(); chk("s1_ab", 2'b11, 1'b0);
      tick(); chk("s3_idle", 2'b11, 1'b0);
      pulse(1'b1, 1'b1, 1'b0); tick(); chk("s3_ab_done", 2'b00, 1'b1);
      tick(); chk("after_done", 2'b00, 1'b0);

      // Priority: reset_Pad wins and a/b are discarded
      pulse(1'b1, 1'b0, 1'b1); tick(); chk("prio_r_a_s0", 2'b00, 1'b0);
      tick(); chk("prio_a_discarded", 2'b00, 1'b0);
      pulse(1'b1, 1'b1, 1'b0); tick(); chk("prio_to_s3", 2'b11, 1'b0);
      pulse(1'b1, 1'b1, 1'b1); tick(); chk("prio_r_ab_s3", 2'b00, 1'b0);
      tick(); chk("prio_ab_discarded", 2'b00, 1'b0);

      // Coalescing: three input1 pulses in one period
      for (int i = 0; i < 3; i++) begin
         input1_Pad = 1'b1; #1;
         input1_Pad = 1'b0; #1;
      end
      tick(); chk("coalesce_a", 2'b01, 1'b0);
      tick(); chk("coalesce_no_extra", 2'b01, 1'b0);
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("coalesce_b", 2'b11, 1'b0);
      pulse(1'b1, 1'b0, 1'b0); tick(); chk("coalesce_done", 2'b00, 1'b1);

      // Async reset mid-sequence with an event pending
      pulse(1'b1, 1'b1, 1'b0); tick(); chk("ar_to_s3", 2'b11, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      #1 rst_n_Pad = 1'b0;
      #1 chk("ar_immediate", 2'b00, 1'b0);
      #1 rst_n_Pad = 1'b1;
      tick(); chk("ar_pending_dropped", 2'b00, 1'b0);
      pulse(1'b1, 1'b0, 1'b0); tick(); chk("ar_recover_a", 2'b01, 1'b0);
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("ar_recover_b", 2'b11, 1'b0);
      pulse(1'b0, 1'b1, 1'b0); tick(); chk("ar_recover_done", 2'b00, 1'b1);
      tick(); chk("ar_final_idle", 2'b00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
